rotary_encoder_counter: RTL

Front-panel rotary encoder front end that produces the `rotary_encoder_reg` byte consumed by the SPI register file (ROTARY_ENCODER, address 0x19). It synchronises and debounces the encoder A/B quadrature pins and push switch, decodes detent clicks into a saturating signed count, and clears on the register file's `rotary_encoder_rd_stb`. It also drives a level event flag, wired into one bit of the register file's `interrupt_input`.

---
 rtl/rotary_encoder_counter_if.sv | 34 +++
 rtl/rotary_encoder_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_encoder_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : rotary_encoder_counter_if
// Description : Register-file side of the rotary encoder front end. It carries
//               the read strobe from the register file and returns the
//               ROTARY_ENCODER byte, the level event flag and the
//               quadrature-error pulse.
//   rotary_encoder_rd_stb : register file -> encoder, one-cycle read-clear
//   rotary_encoder_reg    : encoder -> register file, {sw_latched, count[6:0]}
//   enc_event             : encoder -> interrupt input, level
//   quad_err              : encoder -> register file, one-cycle pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface rotary_encoder_counter_if;
    logic       rotary_encoder_rd_stb;
    logic [7:0] rotary_encoder_reg;
    logic       enc_event;
    logic       quad_err;

    modport master (
        output rotary_encoder_rd_stb,
        input  rotary_encoder_reg,
        input  enc_event,
        input  quad_err
    );

    modport slave (
        input  rotary_encoder_rd_stb,
        output rotary_encoder_reg,
        output enc_event,
        output quad_err
    );
endinterface
`default_nettype wire

// File: rtl/rotary_encoder_counter.sv
`default_nettype none
// ============================================================================
// Module      : rotary_encoder_counter
// Description : Front-panel rotary encoder front end. Synchronises and
//               debounces the A/B quadrature pins (and optionally the push
//               switch), decodes detent clicks into a saturating 7-bit signed
//               count and clears on the register-file read strobe.
// Ports       :
//   clk      in  : system clock, rising edge
//   reset_n  in  : asynchronous active-low reset
//   enc_a    in  : encoder phase A (asynchronous, idle high)
//   enc_b    in  : encoder phase B (asynchronous, idle high)
//   enc_sw   in  : push switch (asynchronous, active low)
//   regif    slave modport of rotary_encoder_counter_if (rd_stb in;
//            rotary_encoder_reg, enc_event, quad_err out)
// Macro       : ROTARY_SWITCH_EN - when defined, the switch path is built and
//               drives bit 7; otherwise enc_sw is ignored and bit 7 reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rotary_encoder_counter #(
    parameter int DEBOUNCE_CYCLES  = 2000,
    parameter int DETENT_THRESHOLD = 2
) (
    input  wire logic                      clk,
    input  wire logic                      reset_n,
    input  wire logic                      enc_a,
    input  wire logic                      enc_b,
    input  wire logic                      enc_sw,
    rotary_encoder_counter_if.slave        regif
);

`ifdef ROTARY_SWITCH_EN
    localparam int c_nin = 3;
`else
    localparam int c_nin = 2;
`endif
    localparam int              c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_deb_max = c_cnt_w'(DEBOUNCE_CYCLES);
    // Accumulator is 4 bits wide so that the +/-4 saturation points are
    // representable.
    localparam logic signed [3:0] c_sub_max = 4'sd4;
    localparam logic signed [3:0] c_sub_min = -4'sd4;
    localparam logic signed [3:0] c_th_pos  = 4'(DETENT_THRESHOLD);
    localparam logic signed [3:0] c_th_neg  = -c_th_pos;
    localparam logic [6:0]        c_cnt_max = 7'h3F;  // +63
    localparam logic [6:0]        c_cnt_min = 7'h40;  // -64

    logic [c_nin-1:0] w_raw;
    logic [c_nin-1:0] w_stable;

`ifdef ROTARY_SWITCH_EN
    assign w_raw = {enc_sw, enc_b, enc_a};
`else
    logic w_unused_sw;
    assign w_unused_sw = enc_sw;
    assign w_raw       = {enc_b, enc_a};
`endif

    // ------------------------------------------------------------------
    // 2-FF synchroniser + debouncer per input. Everything idles high so
    // the decoder starts from the detent position after reset.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < c_nin; gi++) begin : g_deb
        logic               r_s1;
        logic               r_s2;
        logic               r_stable;
        logic [c_cnt_w-1:0] r_cnt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_s1     <= 1'b1;
                r_s2     <= 1'b1;
                r_stable <= 1'b1;
                r_cnt    <= '0;
            end else begin
                r_s1 <= w_raw[gi];
                r_s2 <= r_s1;
                if (r_s2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_deb_max) begin
                    r_stable <= r_s2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_stable[gi] = r_stable;
    end

    // ------------------------------------------------------------------
    // Quadrature decode. Gray position along the forward sequence
    // 11->01->00->10 is 0..3; the modulo-4 difference gives the direction
    // (1 forward, 3 reverse, 2 illegal double change).
    // ------------------------------------------------------------------
    function automatic logic [1:0] f_pos(input logic [1:0] ab);
        return {~ab[0], ab[1] ^ ab[0]};
    endfunction

    logic [1:0]        w_ab;
    logic [1:0]        w_step;
    logic [1:0]        r_ab_q;
    logic signed [3:0] r_sub;
    logic signed [3:0] w_sub_nxt;
    logic              w_inc;
    logic              w_dec;
    logic              w_err;
    logic              r_inc;
    logic              r_dec;
    logic              r_quad_err;

    assign w_ab   = {w_stable[0], w_stable[1]};
    assign w_step = f_pos(w_ab) - f_pos(r_ab_q);

    always_comb begin
        w_sub_nxt = r_sub;
        w_inc     = 1'b0;
        w_dec     = 1'b0;
        w_err     = 1'b0;
        case (w_step)
            2'd1:    if (r_sub != c_sub_max) w_sub_nxt = r_sub + 4'sd1;
            2'd3:    if (r_sub != c_sub_min) w_sub_nxt = r_sub - 4'sd1;
            2'd2:    w_err = 1'b1;
            default: ;
        endcase
        // Arrival at the detent resolves the accumulated quarter steps,
        // including the step that arrived. Partial turns that back out
        // net to zero and are dropped here.
        if (w_ab == 2'b11 && r_ab_q != 2'b11) begin
            if (w_sub_nxt >= c_th_pos) begin
                w_inc = 1'b1;
            end else if (w_sub_nxt <= c_th_neg) begin
                w_dec = 1'b1;
            end
            w_sub_nxt = 4'sd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ab_q     <= 2'b11;
            r_sub      <= 4'sd0;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_quad_err <= 1'b0;
        end else begin
            r_ab_q     <= w_ab;
            r_sub      <= w_sub_nxt;
            r_inc      <= w_inc;
            r_dec      <= w_dec;
            r_quad_err <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Count, switch latch and event flag.
    // ------------------------------------------------------------------
    logic [6:0] r_count;
    logic [6:0] w_cnt_nxt;
    logic       w_sw_nxt;
    logic       w_sw_bit;
    logic       r_event;

    always_comb begin
        w_cnt_nxt = r_count;
        if (regif.rotary_encoder_rd_stb) begin
            // A click landing with the read strobe survives as +/-1.
            if (r_inc) begin
                w_cnt_nxt = 7'h01;
            end else if (r_dec) begin
                w_cnt_nxt = 7'h7F;
            end else begin
                w_cnt_nxt = 7'h00;
            end
        end else if (r_inc && r_count != c_cnt_max) begin
            w_cnt_nxt = r_count + 7'd1;
        end else if (r_dec && r_count != c_cnt_min) begin
            w_cnt_nxt = r_count - 7'd1;
        end
    end

`ifdef ROTARY_SWITCH_EN
    logic r_sw_q;
    logic r_sw_latched;
    logic w_sw_fall;

    assign w_sw_fall = r_sw_q & ~w_stable[2];

    // A press coinciding with the read strobe wins.
    always_comb begin
        w_sw_nxt = r_sw_latched;
        if (w_sw_fall) begin
            w_sw_nxt = 1'b1;
        end else if (regif.rotary_encoder_rd_stb) begin
            w_sw_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_q       <= 1'b1;
            r_sw_latched <= 1'b0;
        end else begin
            r_sw_q       <= w_stable[2];
            r_sw_latched <= w_sw_nxt;
        end
    end

    assign w_sw_bit = r_sw_latched;
`else
    assign w_sw_nxt = 1'b0;
    assign w_sw_bit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 7'h00;
            r_event <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_event <= (w_cnt_nxt != 7'h00) | w_sw_nxt;
        end
    end

    assign regif.rotary_encoder_reg = {w_sw_bit, r_count};
    assign regif.enc_event          = r_event;
    assign regif.quad_err           = r_quad_err;

endmodule
`default_nettype wire
